// File: rtl/wave_osc.sv
// Multi-mode oscillator: ACC_W-bit phase accumulator feeding a registered
// triangle / saw / square / pulse sample, plus wrap strobe and 8-bit phase tap.
module wave_osc #(
  parameter int ACC_W = 16,
  parameter int OUT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [ACC_W-1:0] freq_inc,
  input  logic [1:0]       mode,
  input  logic [7:0]       duty,
  input  logic             sync,
  output logic [OUT_W-1:0] out,
  output logic             wrap,
  output logic [7:0]       phase
);

  typedef enum logic [1:0] {
    MODE_TRI   = 2'd0,
    MODE_SAW   = 2'd1,
    MODE_SQR   = 2'd2,
    MODE_PULSE = 2'd3
  } wave_mode_t;

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_nxt_s;
  wave_mode_t       mode_r;
  wave_mode_t       mode_nxt_s;
  logic             wrap_nxt_s;
  logic [ACC_W:0]   sum_s;
  logic [OUT_W-1:0] wave_s;

  // Waveform shaping from the top OUT_W+1 accumulator bits (pulse uses the 8-bit phase).
  function automatic logic [OUT_W-1:0] wave_fn(
    input logic [ACC_W-1:0] acc,
    input wave_mode_t       md,
    input logic [7:0]       dt
  );
    logic [OUT_W:0]   t;
    logic [7:0]       ph;
    logic [OUT_W-1:0] r;
    t  = acc[ACC_W-1 -: OUT_W+1];
    ph = acc[ACC_W-1 -: 8];
    case (md)
      MODE_TRI:   r = t[OUT_W] ? ~t[OUT_W-1:0] : t[OUT_W-1:0];
      MODE_SAW:   r = t[OUT_W:1];
      MODE_SQR:   r = t[OUT_W] ? {OUT_W{1'b0}} : {OUT_W{1'b1}};
      MODE_PULSE: r = (ph < dt) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
      default:    r = {OUT_W{1'b0}};
    endcase
    return r;
  endfunction

  assign sum_s  = {1'b0, acc_r} + {1'b0, freq_inc};
  assign wave_s = wave_fn(acc_r, mode_r, duty);
  assign phase  = acc_r[ACC_W-1 -: 8];

  // Next-state: sync beats enable; mode is only latched on sync or carry.
  always_comb begin
    acc_nxt_s  = acc_r;
    mode_nxt_s = mode_r;
    wrap_nxt_s = 1'b0;
    if (sync) begin
      acc_nxt_s  = {ACC_W{1'b0}};
      mode_nxt_s = wave_mode_t'(mode);
    end else if (en) begin
      acc_nxt_s  = sum_s[ACC_W-1:0];
      wrap_nxt_s = sum_s[ACC_W];
      if (sum_s[ACC_W]) begin
        mode_nxt_s = wave_mode_t'(mode);
      end else begin
        mode_nxt_s = mode_r;
      end
    end else begin
      acc_nxt_s  = acc_r;
      wrap_nxt_s = 1'b0;
    end
  end

  // State and output registers; the sample reflects the pre-edge phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= {ACC_W{1'b0}};
      mode_r <= MODE_TRI;
      wrap   <= 1'b0;
      out    <= {OUT_W{1'b0}};
    end else begin
      acc_r  <= acc_nxt_s;
      mode_r <= mode_nxt_s;
      wrap   <= wrap_nxt_s;
      out    <= wave_s;
    end
  end

endmodule

// File: tb/tb_wave_osc.sv
// Scoreboard bench for wave_osc: a driver advances an arithmetic phase model and
// queues expected samples; a monitor pops and compares on every falling edge.
`timescale 1ns/1ps
module tb_wave_osc;
  localparam int ACC_W = 16;
  localparam int OUT_W = 7;
  localparam longint MODULUS = longint'(1) << ACC_W;
  localparam int HALF = 1 << OUT_W;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [ACC_W-1:0] freq_inc;
  logic [1:0]       mode;
  logic [7:0]       duty;
  logic             sync;
  logic [OUT_W-1:0] out;
  logic             wrap;
  logic [7:0]       phase;

  typedef struct packed {
    logic [OUT_W-1:0] out;
    logic             wrap;
    logic [7:0]       phase;
  } exp_t;

  exp_t   q[$];
  exp_t   mon_x;
  int     vectors = 0;
  int     miscompares = 0;
  longint m_acc = 0;
  int     m_mode = 0;

  wave_osc #(.ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .freq_inc(freq_inc), .mode(mode),
    .duty(duty), .sync(sync), .out(out), .wrap(wrap), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference waveform from plain arithmetic on the phase fraction.
  function automatic int model_wave(input longint acc, input int md, input logic [7:0] dt);
    int t;
    int ph;
    t  = int'(acc >> (ACC_W - OUT_W - 1));
    ph = int'(acc >> (ACC_W - 8));
    case (md)
      0: return (t < HALF) ? t : (2 * HALF - 1 - t);
      1: return t / 2;
      2: return (t < HALF) ? HALF - 1 : 0;
      3: return (ph < int'(dt)) ? HALF - 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic step(input logic e, input logic s, input logic [ACC_W-1:0] inc,
                      input logic [1:0] md, input logic [7:0] dt);
    exp_t   x;
    longint sum;
    @(negedge clk);
    en = e; sync = s; freq_inc = inc; mode = md; duty = dt;
    @(posedge clk);
    x.out = OUT_W'(model_wave(m_acc, m_mode, dt));
    x.wrap = 1'b0;
    if (s) begin
      m_acc  = 0;
      m_mode = int'(md);
    end else if (e) begin
      sum   = m_acc + longint'(inc);
      x.wrap = (sum >= MODULUS);
      m_acc = sum % MODULUS;
      if (x.wrap) m_mode = int'(md);
    end
    x.phase = 8'(m_acc >> (ACC_W - 8));
    q.push_back(x);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out"}, 16'(out), 16'h0000);
    check({tag, "_wrap"}, 16'(wrap), 16'h0000);
    check({tag, "_phase"}, 16'(phase), 16'h0000);
  endtask

  // Monitor: every cycle presents a sample; compare it against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      mon_x = q.pop_front();
      check("out", 16'(out), 16'(mon_x.out));
      check("wrap", 16'(wrap), 16'(mon_x.wrap));
      check("phase", 16'(phase), 16'(mon_x.phase));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int guard;
    logic [ACC_W-1:0] rinc;
    logic [7:0] rdt;
    rst_n = 1'b0; en = 1'b1; freq_inc = 16'h1234; mode = 2'd0; duty = 8'h00; sync = 1'b0;

    // Reset held with enable active
    repeat (4) begin
      @(negedge clk); #1;
      check_zero("reset_hold");
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 16'h1234, 2'd0, 8'h00);
    step(1'b1, 1'b0, 16'h1234, 2'd0, 8'h00);

    // Triangle sweep
    step(1'b1, 1'b1, 16'h0100, 2'd0, 8'h00);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 16'h0100, 2'd0, 8'h00);

    // Deferred mode change to square, then saw
    guard = 0;
    while (((m_acc >> 8) & 255) != 'h40 && guard < 300) begin
      step(1'b1, 1'b0, 16'h0100, 2'd0, 8'h00);
      guard++;
    end
    for (int i = 0; i < 512; i++) step(1'b1, 1'b0, 16'h0100, 2'd2, 8'h00);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 16'h0100, 2'd1, 8'h00);

    // Pulse at several duty settings including the extremes
    step(1'b1, 1'b1, 16'h0100, 2'd3, 8'h40);
    for (int i = 0; i < 257; i++) step(1'b1, 1'b0, 16'h0100, 2'd3, 8'h40);
    for (int i = 0; i < 257; i++) step(1'b1, 1'b0, 16'h0100, 2'd3, 8'h00);
    for (int i = 0; i < 257; i++) step(1'b1, 1'b0, 16'h0100, 2'd3, 8'hFF);

    // Priorities, hold and zero increment
    step(1'b1, 1'b1, 16'hFF80, 2'd0, 8'h00);
    step(1'b1, 1'b0, 16'hFF80, 2'd0, 8'h00);
    step(1'b1, 1'b1, 16'h0100, 2'd0, 8'h00);
    step(1'b1, 1'b0, 16'h3300, 2'd0, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0100, 2'd1, 8'h00);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 16'h0000, 2'd2, 8'h80);

    // Saw active at phase 0x9A, then async reset between edges
    step(1'b1, 1'b1, 16'h0100, 2'd0, 8'h00);
    guard = 0;
    while (!(m_mode == 1 && ((m_acc >> 8) & 255) == 'h9A) && guard < 1000) begin
      step(1'b1, 1'b0, 16'h0100, 2'd1, 8'h00);
      guard++;
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_clocked");
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_acc = 0;
    m_mode = 0;
    for (int i = 0; i < 120; i++) step(1'b1, 1'b0, 16'h0100, 2'd1, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rinc = ($urandom_range(0, 3) == 0) ? ACC_W'($urandom) : ACC_W'($urandom_range(0, 2048));
      if ($urandom_range(0, 19) == 0) rinc = '0;
      case ($urandom_range(0, 3))
        0: rdt = 8'h00;
        1: rdt = 8'hFF;
        default: rdt = 8'($urandom);
      endcase
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 49) == 0),
           rinc, 2'($urandom), rdt);
    end

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending samples, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
